// File: rtl/ha_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : ha_serial_seq
// Description : Bit-serial adder built around a single half-adder cell.
//               Each operand bit takes two cycles: P1 adds a[i]+b[i] and
//               keeps the partial sum/carry, P2 folds the running carry into
//               that partial sum. The result fills LSB first. A one-cycle
//               DONE state then presents the result and the carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module ha_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o,
    output logic             done_o
);

    // Bit index width: ceil(log2(WIDTH)), never less than one bit.
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_P2   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              s1_q, s1_d;
    logic              c1_q, c1_d;
    logic              cout_q, cout_d;

    // The one and only adder cell; both phases share it through this mux.
    logic ha_x;
    logic ha_y;
    logic ha_s;
    logic ha_c;

    assign ha_s = ha_x ^ ha_y;
    assign ha_c = ha_x & ha_y;

    // Steer the half-adder inputs: operand bits in P1, partial sum and carry in P2.
    always_comb begin
        ha_x = 1'b0;
        ha_y = 1'b0;
        case (state_q)
            ST_P1: begin
                ha_x = a_q[idx_q];
                ha_y = b_q[idx_q];
            end
            ST_P2: begin
                ha_x = s1_q;
                ha_y = carry_q;
            end
            default: begin
                ha_x = 1'b0;
                ha_y = 1'b0;
            end
        endcase
    end

    // Next-state and datapath update for the IDLE/P1/P2/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        s1_d    = s1_q;
        c1_d    = c1_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                // start is looked at only here, so pulses during an
                // operation are simply dropped rather than queued.
                if (start_i) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    carry_d = cin_i;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ST_P1;
                end
            end

            ST_P1: begin
                s1_d    = ha_s;
                c1_d    = ha_c;
                state_d = ST_P2;
            end

            ST_P2: begin
                // Full-adder carry = c1 | c; both cannot be 1 at once.
                sum_d[idx_q] = ha_s;
                carry_d      = c1_q | ha_c;
                if (idx_q == IDX_LAST) begin
                    cout_d  = c1_q | ha_c;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_P1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            s1_q    <= s1_d;
            c1_q    <= c1_d;
            cout_q  <= cout_d;
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ha_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ha_serial_seq
// Description : Self-checking bench for ha_serial_seq. Four instances
//               (WIDTH = 1, 4, 8, 16); directed scenarios use the 8-bit one,
//               the random run exercises all four against an arithmetic
//               reference model of the result and its timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ha_serial_seq;

    localparam int NW = 4;
    localparam int D8 = 2;          // index of the WIDTH=8 instance

    function automatic int width_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 16;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        start_r [NW];
    logic [15:0] opa     [NW];
    logic [15:0] opb     [NW];
    logic        cin_r   [NW];
    logic [15:0] sum16   [NW];
    logic        cout_w  [NW];
    logic        busy_w  [NW];
    logic        done_w  [NW];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NW; g++) begin : g_dut
        localparam int W = width_of(g);
        logic [W-1:0] s;
        ha_serial_seq #(.WIDTH(W)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start_i (start_r[g]),
            .op_a_i  (opa[g][W-1:0]),
            .op_b_i  (opb[g][W-1:0]),
            .cin_i   (cin_r[g]),
            .sum_o   (s),
            .cout_o  (cout_w[g]),
            .busy_o  (busy_w[g]),
            .done_o  (done_w[g])
        );
        assign sum16[g] = 16'(s);
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NW; g++) begin
            checks++;
            if (sum16[g] !== 16'h0 || cout_w[g] !== 1'b0 || busy_w[g] !== 1'b0 || done_w[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state w=%0d: sum=%h cout=%b busy=%b done=%b, required all zero",
                         width_of(g), sum16[g], cout_w[g], busy_w[g], done_w[g]);
            end
        end
        rst = 1'b0;
    endtask

    // Directed 8-bit vectors with cycle-by-cycle checks of busy, done,
    // LSB-first fill and carry-out timing.
    task automatic test_basic();
        logic [7:0] ta [5] = '{8'h03, 8'hFF, 8'hFF, 8'hA5, 8'h00};
        logic [7:0] tb [5] = '{8'h05, 8'h01, 8'hFF, 8'h5A, 8'h00};
        logic       tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int v = 0; v < 5; v++) begin
            int exp;
            int part;
            @(negedge clk);
            opa[D8] = 16'(ta[v]); opb[D8] = 16'(tb[v]); cin_r[D8] = tc[v];
            start_r[D8] = 1'b1;
            exp = int'(ta[v]) + int'(tb[v]) + int'(tc[v]);
            for (int k = 0; k <= 17; k++) begin
                @(negedge clk);
                if (k == 0) start_r[D8] = 1'b0;
                part = exp & ((1 << ((k / 2 > 8) ? 8 : k / 2)) - 1);
                checks++;
                if (busy_w[D8] !== (k <= 16)) begin
                    errors++;
                    $display("FAIL basic_busy v=%0d k=%0d: got %b required %b", v, k, busy_w[D8], (k <= 16));
                end
                checks++;
                if (done_w[D8] !== (k == 16)) begin
                    errors++;
                    $display("FAIL basic_done v=%0d k=%0d: got %b required %b", v, k, done_w[D8], (k == 16));
                end
                checks++;
                if (int'(sum16[D8]) !== part) begin
                    errors++;
                    $display("FAIL basic_sum v=%0d k=%0d: got %h required %h", v, k, sum16[D8], part);
                end
                checks++;
                if (cout_w[D8] !== ((k >= 16) ? exp[8] : 1'b0)) begin
                    errors++;
                    $display("FAIL basic_cout v=%0d k=%0d: got %b required %b", v, k, cout_w[D8],
                             ((k >= 16) ? exp[8] : 1'b0));
                end
            end
        end
    endtask

    // start held high: back-to-back operations every 18 edges, no restarts.
    task automatic test_back_to_back();
        @(negedge clk);
        opa[D8] = 16'h10; opb[D8] = 16'h20; cin_r[D8] = 1'b0; start_r[D8] = 1'b1;
        for (int k = 0; k <= 53; k++) begin
            @(negedge clk);
            checks++;
            if (done_w[D8] !== ((k % 18) == 16)) begin
                errors++;
                $display("FAIL b2b_done k=%0d: got %b required %b", k, done_w[D8], ((k % 18) == 16));
            end
            checks++;
            if (busy_w[D8] !== ((k % 18) != 17)) begin
                errors++;
                $display("FAIL b2b_busy k=%0d: got %b required %b", k, busy_w[D8], ((k % 18) != 17));
            end
            if ((k % 18) == 16) begin
                checks++;
                if (sum16[D8] !== 16'h30 || cout_w[D8] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result k=%0d: got cout=%b sum=%h required cout=0 sum=30", k, cout_w[D8], sum16[D8]);
                end
            end
            if (k == 53) start_r[D8] = 1'b0;
        end
    endtask

    // start pulse mid-operation is dropped; operand changes do not leak in.
    task automatic test_ignore_start();
        @(negedge clk);
        opa[D8] = 16'h12; opb[D8] = 16'h34; cin_r[D8] = 1'b1; start_r[D8] = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0) start_r[D8] = 1'b0;
            if (k == 4) start_r[D8] = 1'b1;
            if (k == 5) begin
                start_r[D8] = 1'b0;
                opa[D8] = 16'($urandom) & 16'hFF;
                opb[D8] = 16'($urandom) & 16'hFF;
                cin_r[D8] = 1'($urandom);
            end
            checks++;
            if (done_w[D8] !== (k == 16) || busy_w[D8] !== (k <= 16)) begin
                errors++;
                $display("FAIL ignore_ctrl k=%0d: got done=%b busy=%b required done=%b busy=%b",
                         k, done_w[D8], busy_w[D8], (k == 16), (k <= 16));
            end
            if (k >= 16) begin
                checks++;
                if (sum16[D8] !== 16'h47 || cout_w[D8] !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_result k=%0d: got cout=%b sum=%h required cout=0 sum=47", k, cout_w[D8], sum16[D8]);
                end
            end
        end
    endtask

    // Asynchronous reset between edges aborts the operation immediately.
    task automatic test_async_reset();
        @(negedge clk);
        opa[D8] = 16'hFF; opb[D8] = 16'h00; cin_r[D8] = 1'b0; start_r[D8] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0) start_r[D8] = 1'b0;
        end
        checks++;
        if (sum16[D8] !== 16'h07 || busy_w[D8] !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got sum=%h busy=%b required sum=07 busy=1", sum16[D8], busy_w[D8]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sum16[D8] !== 16'h0 || cout_w[D8] !== 1'b0 || busy_w[D8] !== 1'b0 || done_w[D8] !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: got sum=%h cout=%b busy=%b done=%b required all zero",
                     sum16[D8], cout_w[D8], busy_w[D8], done_w[D8]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (done_w[D8] !== 1'b0 || busy_w[D8] !== 1'b0) begin
                errors++;
                $display("FAIL areset_quiet k=%0d: got done=%b busy=%b required 0 0", k, done_w[D8], busy_w[D8]);
            end
        end
        opa[D8] = 16'h55; opb[D8] = 16'h2A; cin_r[D8] = 1'b1; start_r[D8] = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            if (k == 0) start_r[D8] = 1'b0;
            checks++;
            if (done_w[D8] !== (k == 16)) begin
                errors++;
                $display("FAIL areset_fresh_done k=%0d: got %b required %b", k, done_w[D8], (k == 16));
            end
            if (k == 16) begin
                checks++;
                if (sum16[D8] !== 16'h80 || cout_w[D8] !== 1'b0) begin
                    errors++;
                    $display("FAIL areset_fresh_result: got cout=%b sum=%h required cout=0 sum=80", cout_w[D8], sum16[D8]);
                end
            end
        end
    endtask

    // Random operands changing every cycle with start held on all four
    // widths. The model: an op is accepted every 2W+2 edges, the result is
    // the arithmetic sum of the operands present on the accept edge, and
    // done appears after the 2W-th edge following acceptance.
    task automatic test_random_widths();
        int       acc  [NW];
        int       dn   [NW];
        int       expv [NW];
        const int N = 3060 * 12;
        for (int g = 0; g < NW; g++) begin
            acc[g] = 0; dn[g] = 0; expv[g] = 0;
        end
        @(negedge clk);
        for (int g = 0; g < NW; g++) begin
            int m = (1 << width_of(g)) - 1;
            opa[g] = 16'($urandom & m); opb[g] = 16'($urandom & m); cin_r[g] = 1'($urandom);
            expv[g] = int'(opa[g]) + int'(opb[g]) + int'(cin_r[g]);
            acc[g]++;
            start_r[g] = 1'b1;
        end
        for (int n = 0; n < N; n++) begin
            @(negedge clk);
            for (int g = 0; g < NW; g++) begin
                int w  = width_of(g);
                int p  = 2 * w + 2;
                int m  = (1 << w) - 1;
                logic ed = ((n % p) == 2 * w);
                checks++;
                if (done_w[g] !== ed || busy_w[g] !== ((n % p) != p - 1)) begin
                    errors++;
                    $display("FAIL rand_ctrl w=%0d n=%0d: got done=%b busy=%b required done=%b busy=%b",
                             w, n, done_w[g], busy_w[g], ed, ((n % p) != p - 1));
                end
                if (ed) begin
                    int got = (int'(cout_w[g]) << w) | int'(sum16[g]);
                    dn[g]++;
                    checks++;
                    if (got !== expv[g]) begin
                        errors++;
                        $display("FAIL rand_result w=%0d n=%0d: got %h required %h", w, n, got, expv[g]);
                    end
                end
                if (n == N - 1) begin
                    start_r[g] = 1'b0;
                end else begin
                    opa[g] = 16'($urandom & m); opb[g] = 16'($urandom & m); cin_r[g] = 1'($urandom);
                    if (((n + 1) % p) == 0) begin
                        expv[g] = int'(opa[g]) + int'(opb[g]) + int'(cin_r[g]);
                        acc[g]++;
                    end
                end
            end
        end
        repeat (4) @(negedge clk);
        for (int g = 0; g < NW; g++) begin
            checks++;
            if (dn[g] !== acc[g] || busy_w[g] !== 1'b0) begin
                errors++;
                $display("FAIL rand_count w=%0d: got dones=%0d busy=%b required dones=%0d busy=0",
                         width_of(g), dn[g], busy_w[g], acc[g]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < NW; g++) begin
            start_r[g] = 1'b0; opa[g] = 16'h0; opb[g] = 16'h0; cin_r[g] = 1'b0;
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_async_reset();
        test_random_widths();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ha_serial_seq.md
HA_SERIAL_SEQ -- requirements
Module: ha_serial_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-004 start  input  1  request pulse/level; sampled only in IDLE.
REQ-005 op_a  input  WIDTH  addend A; captured on accepting edge.
REQ-006 op_b  input  WIDTH  addend B; captured on accepting edge.
REQ-007 cin  input  1  carry-in; captured on accepting edge.
REQ-008 sum  output  WIDTH  result register, LSB-first fill.
REQ-009 cout  output  1  final carry-out.
REQ-010 busy  output  1  high in P1, P2, DONE.
REQ-011 done  output  1  one-cycle result-valid strobe.

Function
REQ-012 Block SHALL contain exactly one half-adder cell (s=x^y, c=x&y); all addition SHALL time-share it, never a second adder.
REQ-013 FSM states SHALL be IDLE, P1, P2, DONE; registered bit index idx, width ceil(log2(WIDTH)) min 1.
REQ-014 IDLE: start=1 at an edge (accept edge E0) -> latch op_a, op_b, cin into carry register; clear sum, cout; idx<=0; go P1.
REQ-015 IDLE with start=0 -> stay IDLE, outputs hold.
REQ-016 P1 (one cycle): half-adder inputs a[idx], b[idx]; register s1 and c1; go P2.
REQ-017 P2 (one cycle): half-adder inputs s1, carry; sum[idx]<=s; carry<=c1|c; if idx==WIDTH-1 go DONE, else idx<=idx+1, go P1.
REQ-018 Bit idx SHALL be written at edge E(2*idx+2); no sum bit written outside P2.
REQ-019 DONE (one cycle): done=1, cout=carry; next edge -> IDLE.
REQ-020 Latency: done high in cycle immediately after edge E(2*WIDTH); (WIDTH=8: after 16th edge post-accept).
REQ-021 start asserted in P1/P2/DONE SHALL be ignored, not queued; held start re-accepted only at first edge in IDLE.
REQ-022 Operand inputs SHALL be don't-care after E0; changes mid-operation SHALL not affect result.
REQ-023 sum, cout SHALL hold final values from DONE until next accept edge.
REQ-024 Result SHALL equal (op_a + op_b + cin) mod 2^WIDTH, cout = bit WIDTH of full sum.
REQ-025 WIDTH=1: single P1/P2 pair, done after E2.
REQ-026 done SHALL never be high for two consecutive cycles; minimum start-to-start spacing 2*WIDTH+2 edges.

Reset
REQ-027 rst=1 SHALL immediately, without clock, force IDLE, idx=0, sum=0, cout=0, busy=0, done=0, internal s1/c1/carry=0.
REQ-028 rst asserted mid-operation SHALL abort; no done strobe for aborted operation.
REQ-029 First accept possible at first rising edge with rst=0 and start=1.

Verification
REQ-030 WIDTH=8, a=0x03, b=0x05, cin=0 -> done after E16, sum=0x08, cout=0, busy high E0..E17 window.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 start held high continuously, a=0x10, b=0x20 -> done pulses every 18 edges, sum=0x30 each, no mid-op restart.
REQ-033 start pulsed at E5 during op, operands changed at E6 -> first result unaffected, second op not started.
REQ-034 rst pulsed between edges at E7 (async) -> outputs zero before next edge, no done; fresh op afterwards correct.
REQ-035 Random 1000 ops WIDTH=1,4,8,16 vs reference sum model -> zero mismatches, done count equals accept count.
